// File: rtl/dot_result_buffer.sv
`default_nettype none
// ============================================================================
// dot_result_buffer : circular FIFO for dot-product results, saturating sum
// Rev 1.0
// ============================================================================
module dot_result_buffer #(
  parameter int DEPTH = 4,
  parameter int SUM_W = 24
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [17:0]              din,
  input  logic                     run,
  input  logic                     clr,
  output logic [17:0]              dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [SUM_W-1:0]         sum
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ((SUM_W > 18) ? SUM_W : 18) + 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [EW-1:0]  SUM_MAX  = {{(EW-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("dot_result_buffer: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [17:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           mask;
  logic           write_req;
  logic           pop;
  logic           full;
  logic           accept;
  logic           drop;
  logic [EW-1:0]  sum_base;
  logic [EW-1:0]  sum_add;
  logic [SUM_W-1:0] sum_next;

  // upstream holds run high through reset, so the first edge after release is masked
  assign write_req  = run & ~mask;
  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;
  assign full       = (count == FULL_CNT);
  assign accept     = write_req & (~full | pop);
  assign drop       = write_req & full & ~pop;
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  // clr zeroes the base so the result accepted on the same edge still lands in sum
  always_comb begin
    sum_base = clr ? '0 : {{(EW-SUM_W){1'b0}}, sum};
    sum_add  = sum_base + (accept ? {{(EW-18){1'b0}}, din} : '0);
    sum_next = (sum_add > SUM_MAX) ? {SUM_W{1'b1}} : sum_add[SUM_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mask   <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mask <= 1'b0;
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // a drop on a clearing edge is recorded after the clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      sum <= sum_next;
      if (clr)       overflow <= drop;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_result_buffer.sv
`default_nettype none
// ============================================================================
// tb_dot_result_buffer : vector table, corner sequences and random vs model
// Rev 1.0
// ============================================================================
module tb_dot_result_buffer;

  localparam int  DEPTH = 4;
  localparam int  SUM_W = 24;
  localparam longint SMAX = (64'd1 << SUM_W) - 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [17:0] din = '0;
  logic        run = 1'b1;
  logic        clr = 1'b0;
  logic        dout_ready = 1'b0;
  logic [17:0] dout;
  logic        dout_valid;
  logic [2:0]  count;
  logic        overflow;
  logic [SUM_W-1:0] sum;

  int checks = 0;
  int errors = 0;

  dot_result_buffer #(.DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clk(clk), .resetn(resetn), .din(din), .run(run), .clr(clr),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .overflow(overflow), .sum(sum)
  );

  always #5 clk = ~clk;

  // reference model: a queue of results plus a scalar sum and flag
  int     q[$];
  longint msum;
  bit     movf;
  bit     mmask;

  task automatic model_reset();
    q.delete();
    msum  = 0;
    movf  = 0;
    mmask = 1;
  endtask

  task automatic model_edge();
    bit wreq, pop, acc, drp;
    longint base;
    wreq = run && !mmask && resetn;
    pop  = (q.size() != 0) && dout_ready;
    acc  = wreq && (q.size() < DEPTH || pop);
    drp  = wreq && !acc;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(int'(din));
    base = clr ? 0 : msum;
    if (acc) base += din;
    msum = (base > SMAX) ? SMAX : base;
    if (clr) movf = drp;
    else if (drp) movf = 1;
    mmask = 0;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".valid"}, dout_valid, q.size() != 0);
    chk({tag, ".dout"}, dout, (q.size() != 0) ? q[0] : 0);
    chk({tag, ".ovf"}, overflow, movf);
    chk({tag, ".sum"}, sum, msum);
  endtask

  // one clock edge; inputs must already be stable, outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input int d, input bit c, input bit rdy);
    run = r; din = 18'(d); clr = c; dout_ready = rdy;
  endtask

  typedef struct {
    bit  run; int din; bit clr; bit rdy;
    int  cnt; int dout; bit ovf; int sum;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // ---------------- reset and masked first edge ----------------
    model_reset();
    drive(1, 0, 0, 0);
    #12;
    chk("rst.count", count, 0);
    chk("rst.valid", dout_valid, 0);
    chk("rst.dout", dout, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.sum", sum, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    step();
    chk("mask.count", count, 0);
    chk("mask.valid", dout_valid, 0);

    // ---------------- table-driven directed vectors ----------------
    vecs = '{
      '{1, 100, 0, 0, 1, 100, 0, 100},
      '{1, 200, 0, 0, 2, 100, 0, 300},
      '{1, 300, 0, 0, 3, 100, 0, 600},
      '{0, 0,   0, 1, 2, 200, 0, 600},
      '{0, 0,   0, 1, 1, 300, 0, 600},
      '{0, 0,   0, 1, 0, 0,   0, 600},
      '{0, 0,   0, 1, 0, 0,   0, 600},
      '{0, 0,   1, 0, 0, 0,   0, 0},
      '{1, 1,   0, 0, 1, 1,   0, 1},
      '{1, 2,   0, 0, 2, 1,   0, 3},
      '{1, 3,   0, 0, 3, 1,   0, 6},
      '{1, 4,   0, 0, 4, 1,   0, 10},
      '{1, 5,   0, 0, 4, 1,   1, 10},
      '{0, 0,   0, 1, 3, 2,   1, 10},
      '{0, 0,   0, 1, 2, 3,   1, 10},
      '{0, 0,   0, 1, 1, 4,   1, 10},
      '{0, 0,   0, 1, 0, 0,   1, 10},
      '{1, 1,   1, 0, 1, 1,   0, 1},
      '{1, 2,   0, 0, 2, 1,   0, 3},
      '{1, 3,   0, 0, 3, 1,   0, 6},
      '{1, 4,   0, 0, 4, 1,   0, 10},
      '{1, 7,   0, 1, 4, 2,   0, 17},
      '{0, 0,   0, 1, 3, 3,   0, 17},
      '{0, 0,   0, 1, 2, 4,   0, 17},
      '{0, 0,   0, 1, 1, 7,   0, 17},
      '{0, 0,   0, 1, 0, 0,   0, 17}
    };
    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].din, vecs[i].clr, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d.count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d.dout", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d.valid", i), dout_valid, vecs[i].cnt != 0);
      chk($sformatf("vec%0d.ovf", i), overflow, vecs[i].ovf);
      chk($sformatf("vec%0d.sum", i), sum, vecs[i].sum);
    end

    // ---------------- saturation sequence ----------------
    drive(0, 0, 1, 1); step();
    for (int i = 0; i < 63; i++) begin
      drive(1, 262143, 0, 1); step();
    end
    drive(1, 162207, 0, 1); step();
    chk("sat.preload", sum, 16677216);
    drive(1, 195075, 0, 1); step();
    chk("sat.top", sum, 24'hFFFFFF);
    drive(1, 50, 0, 1); step();
    chk("sat.hold", sum, 24'hFFFFFF);
    drive(1, 9, 1, 1); step();
    chk("clrw.sum", sum, 9);
    chk("clrw.ovf", overflow, 0);
    check_model("clrw");

    // ---------------- drop coinciding with clr ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1, 11, 0, 0); step();
    end
    chk("fill.count", count, 4);
    drive(1, 12, 1, 0); step();
    chk("dropclr.ovf", overflow, 1);
    chk("dropclr.sum", sum, 0);
    chk("dropclr.count", count, 4);
    drive(0, 0, 0, 0); step();
    chk("ovf.sticky", overflow, 1);
    check_model("dropclr");

    // ---------------- random traffic against the model ----------------
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, ($urandom_range(0, 3) == 0) ? 18'h3FFFF : $urandom_range(0, 262143),
            $urandom_range(0, 29) == 0, $urandom_range(0, 99) < 45);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 40 + i, 0, 0); step();
    end
    chk("pre_arst.count", count, 3);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("arst.count", count, 0);
    chk("arst.valid", dout_valid, 0);
    chk("arst.sum", sum, 0);
    chk("arst.dout", dout, 0);
    chk("arst.ovf", overflow, 0);
    step();
    resetn = 1'b1;
    drive(1, 0, 0, 0);
    step();
    check_model("rel");
    drive(1, 77, 0, 0);
    step();
    chk("rel.first_write", dout, 77);
    check_model("rel2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_result_buffer.md
DOT_RESULT_BUFFER -- requirements
Module: dot_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered results; only power-of-two values 2..16 are supported.
REQ-002 SHALL have parameter SUM_W, default 24, width of the running-sum output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port din, input, 18, dot-product result from the upstream stage.
REQ-006 SHALL have port run, input, 1, result-valid pulse from the upstream stage.
REQ-007 SHALL have port clr, input, 1, synchronous clear of sum and overflow.
REQ-008 SHALL have port dout, output, 18, head-of-buffer result.
REQ-009 SHALL have port dout_valid, output, 1, high when the buffer is non-empty.
REQ-010 SHALL have port dout_ready, input, 1, consumer accepts dout when high with dout_valid.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, number of stored results (0..DEPTH).
REQ-012 SHALL have port overflow, output, 1, sticky flag set when a result is dropped.
REQ-013 SHALL have port sum, output, SUM_W, saturating sum of all accepted results.

Function
REQ-014 Capture: a write request SHALL occur on an edge where run=1 and the post-reset mask is clear.
REQ-015 Post-reset mask: the mask SHALL be set by reset and cleared on the first rising edge after resetn deasserts; run on that first edge SHALL be ignored, because the upstream stage holds run=1 through reset.
REQ-016 Pop: a pop SHALL occur on an edge where dout_valid=1 and dout_ready=1, and the read pointer SHALL then advance.
REQ-017 Storage: the buffer SHALL be a circular FIFO with write and read pointers that wrap modulo DEPTH.
REQ-018 Latency: a result written on edge N SHALL be visible on dout with dout_valid=1 after edge N; there SHALL be no combinational bypass from din to dout.
REQ-019 dout SHALL equal the entry at the read pointer when count>0, and SHALL be 0 when count=0.
REQ-020 dout_valid SHALL equal (count != 0), decoded combinationally from registered state.
REQ-021 Full without pop: a write request with count=DEPTH and no pop on the same edge SHALL drop the result, set overflow=1, and leave storage and count unchanged.
REQ-022 Full with pop: a write request with count=DEPTH and a pop on the same edge SHALL accept the result, and count SHALL stay at DEPTH.
REQ-023 Push only: count SHALL increment by 1.
REQ-024 Pop only: count SHALL decrement by 1.
REQ-025 Push and pop together: count SHALL be unchanged.
REQ-026 Empty: dout_ready while count=0 SHALL have no effect.
REQ-027 Sum: each accepted result SHALL be added to sum, zero-extended; the sum SHALL saturate at 2^SUM_W-1 and never wrap.
REQ-028 Dropped results SHALL NOT be added to sum.
REQ-029 clr has priority: when asserted, overflow SHALL be set to 0 and sum SHALL be loaded with the result accepted on that edge, or 0 if none.
REQ-030 Drop with clr: if a drop coincides with clr, overflow SHALL be set to 1, because the drop is recorded after the clear.
REQ-031 clr SHALL NOT affect the FIFO contents, the pointers or count.
REQ-032 overflow SHALL stay set until clr or reset.

Reset
REQ-033 On resetn=0 the block SHALL asynchronously set pointers=0, count=0, dout_valid=0, dout=0, overflow=0, sum=0, mask=1 and all storage entries=0.
REQ-034 A reset asserted mid-operation SHALL discard all buffered results immediately, with no partial write.

Verification
REQ-035 Reset release with run=1, din=0 on the first edge -> count stays 0 and dout_valid stays 0.
REQ-036 Write 100, 200 and 300 on consecutive run pulses with dout_ready=0 -> count=3, dout=100, sum=600; then hold dout_ready=1 -> dout reads 100, 200, 300 on successive cycles and count returns to 0.
REQ-037 Write 5 results of 1..5 into DEPTH=4 with dout_ready=0 -> the fifth result is dropped, overflow=1, count=4, sum=10, and the buffer drains as 1, 2, 3, 4.
REQ-038 With count=4, assert run with din=7 together with a pop -> count remains 4, overflow=0, and the last entry drained is 7.
REQ-039 Preload sum to 2^24-100000, then write 195075 -> sum=16777215; assert clr together with a write of 9 -> sum=9 and overflow=0.
REQ-040 Assert resetn=0 between clock edges with count=3 -> count=0, dout_valid=0 and sum=0 immediately, without waiting for a clock edge.
